// File: rtl/hilo_muldiv.sv
// Iterative MULTU/DIVU unit that produces the HI/LO pair read by MFHI/MFLO.
// Shift-add multiply and restoring divide, one iteration per clock over WIDTH cycles.
module hilo_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       Signal,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut
);

  typedef enum logic {IDLE, CALC} state_t;

  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic [WIDTH-1:0]   oper;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quo_next;

  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, oper} : '0);
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    div_shift = {rem, quo[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, oper});
    // A successful trial difference is below the divisor, so the low WIDTH bits are exact.
    div_diff  = div_shift[WIDTH-1:0] - oper;
    rem_next  = div_ge ? div_diff : div_shift[WIDTH-1:0];
    quo_next  = {quo[WIDTH-2:0], div_ge};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      oper   <= '0;
      acc    <= '0;
      rem    <= '0;
      quo    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      HiOut  <= '0;
      LoOut  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && (Signal == F_MULTU || Signal == F_DIVU)) begin
            state  <= CALC;
            busy   <= 1'b1;
            cnt    <= '0;
            is_div <= (Signal == F_DIVU);
            if (Signal == F_DIVU) begin
              oper <= dataB;
              rem  <= '0;
              quo  <= dataA;
              acc  <= '0;
            end else begin
              oper <= dataA;
              acc  <= {{WIDTH{1'b0}}, dataB};
              rem  <= '0;
              quo  <= '0;
            end
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            rem <= rem_next;
            quo <= quo_next;
          end else begin
            acc <= mul_next;
          end
          if (cnt == LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            HiOut <= is_div ? rem_next : mul_next[2*WIDTH-1:WIDTH];
            LoOut <= is_div ? quo_next : mul_next[WIDTH-1:0];
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed self-checking bench for hilo_muldiv with hand-computed HI/LO results.
module tb_hilo_muldiv;

  localparam int W = 32;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] dataA, dataB;
  logic [5:0]   Signal;
  logic         start;
  logic         busy, done;
  logic [W-1:0] HiOut, LoOut;

  int total = 0;
  int bad   = 0;

  hilo_muldiv #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .dataA  (dataA),
    .dataB  (dataB),
    .Signal (Signal),
    .start  (start),
    .busy   (busy),
    .done   (done),
    .HiOut  (HiOut),
    .LoOut  (LoOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issues a request just after an edge, then steps E0..EWIDTH; returns #1 after EWIDTH.
  task automatic run_op(input logic [5:0] sig, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit scramble, input bit inject,
                        input logic [W-1:0] ph, input logic [W-1:0] pl,
                        output int busy_cnt, output int done_cnt);
    Signal = sig; dataA = a; dataB = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_cnt = busy ? 1 : 0;
    done_cnt = 0;
    for (int i = 1; i <= W; i++) begin
      if (scramble) begin
        dataA = $urandom; dataB = $urandom; Signal = 6'($urandom);
      end
      if (inject && i == 10) begin
        Signal = F_DIVU; dataA = 100; dataB = 7; start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (i < W) begin
        if (busy) busy_cnt++;
        if (done) done_cnt++;
      end
      if (i == W / 2) begin
        chk("hold_hi", HiOut, ph);
        chk("hold_lo", LoOut, pl);
      end
    end
  endtask

  task automatic idle_watch(input int n, output int busy_cnt, output int done_cnt);
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (busy) busy_cnt++;
      if (done) done_cnt++;
    end
  endtask

  int bc, dc;

  initial begin
    reset = 1'b0; start = 1'b0; Signal = '0; dataA = '0; dataB = '0;
    #12;
    chk("rst_hi", HiOut, '0);
    chk("rst_lo", LoOut, '0);
    chk("rst_busy", {31'b0, busy}, '0);
    chk("rst_done", {31'b0, done}, '0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // MULTU max
    run_op(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, '0, '0, bc, dc);
    chk("mulmax_busycnt", bc, 32);
    chk("mulmax_early_done", dc, 0);
    chk("mulmax_done", {31'b0, done}, 1);
    chk("mulmax_busy", {31'b0, busy}, 0);
    chk("mulmax_hi", HiOut, 32'hFFFFFFFE);
    chk("mulmax_lo", LoOut, 32'h00000001);
    @(posedge clk); #1;
    chk("mulmax_done_pulse", {31'b0, done}, 0);
    chk("mulmax_hi_hold", HiOut, 32'hFFFFFFFE);

    // DIVU 100/7 with operands scrambled after acceptance
    run_op(F_DIVU, 100, 7, 1, 0, 32'hFFFFFFFE, 32'h1, bc, dc);
    chk("div7_busycnt", bc, 32);
    chk("div7_done", {31'b0, done}, 1);
    chk("div7_hi", HiOut, 2);
    chk("div7_lo", LoOut, 14);
    @(posedge clk); #1;

    // DIVU by zero
    run_op(F_DIVU, 32'h12345678, 0, 0, 0, 2, 14, bc, dc);
    chk("div0_done", {31'b0, done}, 1);
    chk("div0_hi", HiOut, 32'h12345678);
    chk("div0_lo", LoOut, 32'hFFFFFFFF);
    @(posedge clk); #1;

    // MULTU 3x5 with a DIVU request injected while busy
    run_op(F_MULTU, 3, 5, 0, 1, 32'h12345678, 32'hFFFFFFFF, bc, dc);
    chk("ign_busycnt", bc, 32);
    chk("ign_done", {31'b0, done}, 1);
    chk("ign_hi", HiOut, 0);
    chk("ign_lo", LoOut, 15);
    Signal = F_MFHI; dataA = 77; dataB = 3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("mfhi_done_after_commit", {31'b0, done}, 0);
    idle_watch(40, bc, dc);
    chk("ign_extra_busy", bc, 0);
    chk("ign_extra_done", dc, 0);
    chk("ign_hi_keep", HiOut, 0);
    chk("ign_lo_keep", LoOut, 15);

    // Reset in the middle of a MULTU
    Signal = F_MULTU; dataA = 32'hFFFF; dataB = 32'hFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
    end
    #1;
    chk("midrst_busy_before", {31'b0, busy}, 1);
    reset = 1'b0;
    #1;
    chk("midrst_hi", HiOut, '0);
    chk("midrst_lo", LoOut, '0);
    chk("midrst_busy", {31'b0, busy}, '0);
    chk("midrst_done", {31'b0, done}, '0);
    @(negedge clk); reset = 1'b1;
    idle_watch(40, bc, dc);
    chk("midrst_no_busy", bc, 0);
    chk("midrst_no_done", dc, 0);
    chk("midrst_hi_after", HiOut, '0);
    chk("midrst_lo_after", LoOut, '0);

    // Back-to-back: DIVU 9/2, then MULTU 6x7 issued on the done cycle
    run_op(F_DIVU, 9, 2, 0, 0, '0, '0, bc, dc);
    chk("b2b_div_done", {31'b0, done}, 1);
    chk("b2b_div_hi", HiOut, 1);
    chk("b2b_div_lo", LoOut, 4);
    run_op(F_MULTU, 6, 7, 0, 0, 1, 4, bc, dc);
    chk("b2b_mul_busycnt", bc, 32);
    chk("b2b_mul_early_done", dc, 0);
    chk("b2b_mul_done", {31'b0, done}, 1);
    chk("b2b_mul_hi", HiOut, 0);
    chk("b2b_mul_lo", LoOut, 42);
    @(posedge clk); #1;
    chk("b2b_done_pulse", {31'b0, done}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
